// File: rtl/trig_gen.sv
// trig_gen: multi-channel one-shot/periodic trigger generator driven by a shared tick prescaler.
module trig_gen #(
  parameter int CNT_WIDTH = 16,
  parameter int N_CH      = 4,
  parameter int PRE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [PRE_WIDTH-1:0]    prescale,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_WIDTH-1:0]    cfg_period,
  input  logic [CNT_WIDTH-1:0]    cfg_width,
  input  logic [N_CH-1:0]         arm,
  output logic [N_CH-1:0]         trig_out,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         done,
  output logic                    tick
);
  localparam int CW = $clog2(N_CH);
  typedef enum logic {IDLE, RUN} state_t;
  logic [PRE_WIDTH-1:0] pre;
  logic [CNT_WIDTH-1:0] cnt[N_CH], cnt_nx[N_CH], period[N_CH], width[N_CH];
  logic [1:0]           mode[N_CH];
  state_t               state[N_CH], state_nx[N_CH];
  logic [N_CH-1:0]      wr, done_nx;
  // tick is gated by rst_n so it stays low while reset is held even with prescale=0
  assign tick = rst_n && en && (pre == prescale);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else if (en) pre <= tick ? '0 : pre + 1'b1;
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr[i]       = cfg_we && (cfg_ch == CW'(i));
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      done_nx[i]  = 1'b0;
      if (wr[i]) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = '0;
      end else if (state[i] == IDLE) begin
        if (arm[i] && (mode[i] == 2'b01 || mode[i] == 2'b10)) begin
          state_nx[i] = RUN;
          cnt_nx[i]   = '0;
        end
      end else if (tick) begin
        if (cnt[i] != period[i]) cnt_nx[i] = cnt[i] + 1'b1;
        else if (mode[i] == 2'b10) cnt_nx[i] = '0;
        else begin
          state_nx[i] = IDLE;
          cnt_nx[i]   = '0;
          done_nx[i]  = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        period[i] <= '0;
        width[i]  <= '0;
        mode[i]   <= 2'b00;
      end
    end else begin
      done <= done_nx;
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
        if (wr[i]) begin
          period[i] <= cfg_period;
          width[i]  <= cfg_width;
          mode[i]   <= cfg_mode;
        end
      end
    end
  end
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      busy[i]     = (state[i] == RUN);
      trig_out[i] = (state[i] == RUN) && (cnt[i] < width[i]);
    end
  end
endmodule

// File: tb/tb_trig_gen.sv
// tb_trig_gen: directed scenarios plus randomized traffic checked against a tick-count reference model.
module tb_trig_gen;
  localparam int CW = 16, NC = 3, PW = 8;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_we = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [1:0] cfg_ch = '0, cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0, cfg_width = '0;
  logic [NC-1:0] arm = '0, trig_out, busy, done, snap_t, snap_b;
  logic tick;
  int total = 0, bad = 0;
  int ps, en_cnt;
  bit m_run[NC], m_done[NC];
  int m_n[NC], m_p[NC], m_w[NC], m_mode[NC];

  trig_gen #(.CNT_WIDTH(CW), .N_CH(NC), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .arm(arm),
    .trig_out(trig_out), .busy(busy), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: m_n counts ticks since arm; the output phase is m_n modulo (period+1)
  function automatic logic [NC-1:0] exp_trig();
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = m_run[c] && ((m_n[c] % (m_p[c] + 1)) < m_w[c]);
    return r;
  endfunction

  task automatic model_clear();
    en_cnt = 0;
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0; m_done[c] = 0; m_n[c] = 0; m_p[c] = 0; m_w[c] = 0; m_mode[c] = 0;
    end
  endtask

  task automatic step();
    logic [NC-1:0] eb, ed;
    bit t;
    #1;
    t = en && ((en_cnt % (ps + 1)) == ps);
    for (int c = 0; c < NC; c++) begin
      eb[c] = m_run[c];
      ed[c] = m_done[c];
    end
    check("trig", trig_out, exp_trig());
    check("busy", busy, eb);
    check("done", done, ed);
    check("tick", tick, t);
    if (en) en_cnt++;
    for (int c = 0; c < NC; c++) begin
      m_done[c] = 0;
      if (cfg_we && int'(cfg_ch) == c) begin
        m_mode[c] = int'(cfg_mode); m_p[c] = int'(cfg_period); m_w[c] = int'(cfg_width); m_run[c] = 0;
      end else if (!m_run[c]) begin
        if (arm[c] && (m_mode[c] == 1 || m_mode[c] == 2)) begin m_run[c] = 1; m_n[c] = 0; end
      end else if (t) begin
        m_n[c]++;
        if (m_mode[c] == 1 && m_n[c] == m_p[c] + 1) begin m_run[c] = 0; m_done[c] = 1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic cfg(int ch, int md, int p, int w);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(md); cfg_period = CW'(p); cfg_width = CW'(w);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_arm(logic [NC-1:0] a);
    arm = a;
    step();
    arm = '0;
  endtask

  task automatic do_reset(int p);
    rst_n = 1'b0; en = 1'b1; cfg_we = 1'b0; arm = '0;
    prescale = PW'(p); ps = p;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check("rst_trig", trig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(0);
    cfg(0, 2, 4, 2);
    pulse_arm(3'b001);
    for (int j = 1; j <= 11; j++) begin
      check("periodic_trig0", trig_out[0], ((j - 1) % 5) < 2);
      step();
    end
    cfg(0, 0, 0, 0);
    cfg(1, 1, 3, 1);
    pulse_arm(3'b010);
    for (int j = 1; j <= 6; j++) begin
      check("oneshot_trig1", trig_out[1], j == 1);
      check("oneshot_busy1", busy[1], j <= 4);
      check("oneshot_done1", done[1], j == 5);
      step();
    end
    do_reset(2);
    for (int j = 0; j < 9; j++) begin
      check("pre_tick", tick, (j % 3) == 2);
      step();
    end
    cfg(0, 2, 7, 3);
    pulse_arm(3'b001);
    repeat (4) step();
    en = 1'b0;
    snap_t = trig_out; snap_b = busy;
    for (int j = 0; j < 5; j++) begin
      check("frz_tick", tick, 0);
      check("frz_trig", trig_out, snap_t);
      check("frz_busy", busy, snap_b);
      step();
    end
    en = 1'b1;
    repeat (12) step();
    do_reset(0);
    cfg(2, 2, 5, 3);
    pulse_arm(3'b100);
    repeat (3) step();
    check("abort_pre_busy2", busy[2], 1);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b01; cfg_period = CW'(2); cfg_width = CW'(1); arm = 3'b100;
    step();
    cfg_we = 1'b0; arm = '0;
    check("abort_busy2", busy[2], 0);
    check("abort_done2", done[2], 0);
    step();
    check("abort_done2_late", done[2], 0);
    pulse_arm(3'b100);
    for (int j = 1; j <= 4; j++) begin
      check("newcfg_trig2", trig_out[2], j == 1);
      check("newcfg_busy2", busy[2], j <= 3);
      check("newcfg_done2", done[2], j == 4);
      step();
    end
    cfg(0, 2, 3, 0);
    cfg(1, 2, 3, 4);
    pulse_arm(3'b011);
    for (int j = 0; j < 10; j++) begin
      check("w0_trig0", trig_out[0], 0);
      check("wbig_trig1", trig_out[1], 1);
      step();
    end
    #1 rst_n = 1'b0;
    #1;
    check("async_trig", trig_out, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_tick", tick, 0);
    do_reset(0);
    pulse_arm(3'b111);
    for (int j = 0; j < 4; j++) begin
      check("post_rst_busy", busy, 0);
      step();
    end
    for (int s = 0; s < 3; s++) begin
      do_reset(int'($urandom_range(0, 3)));
      repeat (1500) begin
        en = ($urandom % 8) != 0;
        cfg_we = ($urandom % 6) == 0;
        cfg_ch = 2'($urandom % 4);
        cfg_mode = 2'($urandom);
        cfg_period = CW'($urandom % 7);
        cfg_width = CW'($urandom % 9);
        arm = NC'($urandom);
        step();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
